// File: rtl/uart_rx_packetizer_if.sv
// FIFO write-side interface for the UART RX packetizer.
// The packetizer drives rx_data/rx_wren; the RX FIFO returns rx_full.
interface uart_rx_packetizer_if #(
  parameter int unsigned USB_PACKET_WIDTH = 32
);
  logic [USB_PACKET_WIDTH-1:0] rx_data;
  logic                        rx_wren;
  logic                        rx_full;

  modport master (output rx_data, output rx_wren, input rx_full);
  modport slave  (input rx_data, input rx_wren, output rx_full);
endinterface

// File: rtl/uart_rx_packetizer.sv
// 16x-oversampled UART receiver that packs each character plus error flags
// into one FIFO word; characters arriving while the FIFO is full are counted.
module uart_rx_packetizer #(
  parameter int unsigned BAUD_RATE        = 9600,
  parameter int unsigned CLOCK_FREQ       = 10000000,
  parameter string       PARITY           = "none",
  parameter int unsigned DATA_BITS        = 8,
  parameter int unsigned STOP_BITS        = 1,
  parameter int unsigned USB_PACKET_WIDTH = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        rx,
  uart_rx_packetizer_if.master        fifo,
  output logic                        rx_busy,
  output logic [7:0]                  drop_count
);

  localparam int unsigned OSR_DIV = CLOCK_FREQ / (BAUD_RATE * 16);
  localparam int unsigned TICK_W  = (OSR_DIV > 1) ? $clog2(OSR_DIV) : 1;
  localparam bit          PAR_EN  = (PARITY != "none");
  localparam bit          PAR_ODD = (PARITY == "odd");

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_WRITE
  } state_t;

  state_t                      r_state;
  state_t                      w_next;
  logic                        r_sync1;
  logic                        r_sync2;
  logic                        w_rx_s;
  logic [TICK_W-1:0]           r_tick_cnt;
  logic                        w_tick;
  logic [3:0]                  r_samp_cnt;
  logic [2:0]                  r_bit_cnt;
  logic                        w_sample;
  logic                        w_start_mid;
  logic                        w_enter_start;
  logic [DATA_BITS-1:0]        r_shift;
  logic                        r_parity_err;
  logic                        r_frame_err;
  logic                        r_overrun;
  logic [7:0]                  r_drop_cnt;
  logic [USB_PACKET_WIDTH-1:0] r_last_data;
  logic [USB_PACKET_WIDTH-1:0] w_packet;
  logic                        w_par_calc;
  logic                        w_wren;
  logic                        w_drop;

  assign w_rx_s        = r_sync2;
  assign w_tick        = (r_tick_cnt == TICK_W'(OSR_DIV - 1));
  assign w_sample      = w_tick && (r_samp_cnt == 4'd15);
  assign w_start_mid   = w_tick && (r_samp_cnt == 4'd7);
  assign w_enter_start = (r_state == S_IDLE) && (w_next == S_START);
  assign w_par_calc    = (^r_shift) ^ w_rx_s;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (!w_rx_s) w_next = S_START;
      S_START:  if (w_start_mid) w_next = w_rx_s ? S_IDLE : S_DATA;
      S_DATA:   if (w_sample && (r_bit_cnt == 3'(DATA_BITS - 1)))
                  w_next = PAR_EN ? S_PARITY : S_STOP;
      S_PARITY: if (w_sample) w_next = S_STOP;
      S_STOP:   if (w_sample && (r_bit_cnt == 3'(STOP_BITS - 1))) w_next = S_WRITE;
      S_WRITE:  w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // Outputs: the fresh packet is muxed onto rx_data during the write cycle
  // so it is valid alongside rx_wren; otherwise the last written word holds.
  always_comb begin
    w_wren = 1'b0;
    w_drop = 1'b0;
    if (r_state == S_WRITE) begin
      if (fifo.rx_full) w_drop = 1'b1;
      else              w_wren = 1'b1;
    end
    fifo.rx_wren = w_wren;
    fifo.rx_data = w_wren ? w_packet : r_last_data;
    rx_busy      = (r_state != S_IDLE);
  end

  always_comb begin
    w_packet                  = '0;
    w_packet[DATA_BITS-1:0]   = r_shift;
    w_packet[8]               = r_parity_err;
    w_packet[9]               = r_frame_err;
    w_packet[10]              = r_overrun;
  end

  assign drop_count = r_drop_cnt;

  // Synchroniser, oversampling tick and bit timing
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1    <= 1'b1;
      r_sync2    <= 1'b1;
      r_tick_cnt <= '0;
      r_samp_cnt <= '0;
      r_bit_cnt  <= '0;
    end else begin
      r_sync1 <= rx;
      r_sync2 <= r_sync1;

      if (w_enter_start || w_tick) r_tick_cnt <= '0;
      else                         r_tick_cnt <= r_tick_cnt + 1'b1;

      if (w_next != r_state) r_samp_cnt <= '0;
      else if (w_tick)       r_samp_cnt <= r_samp_cnt + 4'd1;

      if (w_next != r_state)
        r_bit_cnt <= '0;
      else if (w_sample && ((r_state == S_DATA) || (r_state == S_STOP)))
        r_bit_cnt <= r_bit_cnt + 3'd1;
    end
  end

  // Character assembly and error flags
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_shift      <= '0;
      r_parity_err <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      if (w_enter_start) begin
        r_parity_err <= 1'b0;
        r_frame_err  <= 1'b0;
      end
      if (w_sample) begin
        case (r_state)
          S_DATA:   r_shift <= {w_rx_s, r_shift[DATA_BITS-1:1]};
          S_PARITY: r_parity_err <= PAR_ODD ? ~w_par_calc : w_par_calc;
          S_STOP:   if (!w_rx_s) r_frame_err <= 1'b1;
          default:  ;
        endcase
      end
    end
  end

  // Write bookkeeping: overrun flag, saturating drop counter, held data word
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_overrun   <= 1'b0;
      r_drop_cnt  <= '0;
      r_last_data <= '0;
    end else begin
      if (w_wren) begin
        r_overrun   <= 1'b0;
        r_last_data <= w_packet;
      end else if (w_drop) begin
        r_overrun <= 1'b1;
        if (r_drop_cnt != 8'hFF) r_drop_cnt <= r_drop_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_packetizer.sv
// Directed bench for uart_rx_packetizer: one no-parity and one even-parity
// instance at 16 clk per bit, each with its own line driven from one source.
module tb_uart_rx_packetizer;

  localparam int unsigned W = 32;

  logic       clk = 1'b0;
  logic       rst;
  logic       line;
  logic       sel_par;
  logic       rx_n;
  logic       rx_p;
  logic       busy_n;
  logic       busy_p;
  logic [7:0] drop_n;
  logic [7:0] drop_p;

  int cyc = 0;
  int frame_cyc0 = 0;
  int wr_cyc_n = 0;
  int n_checks = 0;
  int n_fail = 0;

  logic [W-1:0] q_n[$];
  logic [W-1:0] q_p[$];

  uart_rx_packetizer_if #(.USB_PACKET_WIDTH(W)) fifo_n ();
  uart_rx_packetizer_if #(.USB_PACKET_WIDTH(W)) fifo_p ();

  assign rx_n = sel_par ? 1'b1 : line;
  assign rx_p = sel_par ? line : 1'b1;

  uart_rx_packetizer #(
    .BAUD_RATE(100000), .CLOCK_FREQ(1600000), .PARITY("none"),
    .DATA_BITS(8), .STOP_BITS(1), .USB_PACKET_WIDTH(W)
  ) dut (
    .clk(clk), .rst(rst), .rx(rx_n), .fifo(fifo_n),
    .rx_busy(busy_n), .drop_count(drop_n)
  );

  uart_rx_packetizer #(
    .BAUD_RATE(100000), .CLOCK_FREQ(1600000), .PARITY("even"),
    .DATA_BITS(8), .STOP_BITS(1), .USB_PACKET_WIDTH(W)
  ) dut_p (
    .clk(clk), .rst(rst), .rx(rx_p), .fifo(fifo_p),
    .rx_busy(busy_p), .drop_count(drop_p)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (fifo_n.rx_wren) begin
      q_n.push_back(fifo_n.rx_data);
      wr_cyc_n = cyc;
    end
    if (fifo_p.rx_wren) q_p.push_back(fifo_p.rx_data);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic pop_n(input string tag, input logic [31:0] exp);
    logic [31:0] got;
    got = 'x;
    if (q_n.size() != 0) got = q_n.pop_front();
    check_eq(tag, got, exp);
  endtask

  task automatic pop_p(input string tag, input logic [31:0] exp);
    logic [31:0] got;
    got = 'x;
    if (q_p.size() != 0) got = q_p.pop_front();
    check_eq(tag, got, exp);
  endtask

  task automatic drive_bit(input logic b);
    line = b;
    repeat (16) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic has_par,
                            input logic par_b, input logic stop_b);
    frame_cyc0 = cyc;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    if (has_par) drive_bit(par_b);
    drive_bit(stop_b);
  endtask

  task automatic idle(input int n);
    line = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst            = 1'b0;
    line           = 1'b1;
    sel_par        = 1'b0;
    fifo_n.rx_full = 1'b0;
    fifo_p.rx_full = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_wren", {31'd0, fifo_n.rx_wren}, 32'd0);
    check_eq("rst_data", fifo_n.rx_data, 32'd0);
    check_eq("rst_busy", {31'd0, busy_n}, 32'd0);
    check_eq("rst_drop", {24'd0, drop_n}, 32'd0);
    rst = 1'b1;
    idle(20);

    // Single character, latency from start edge to strobe
    send_frame(8'hA5, 1'b0, 1'b0, 1'b1);
    idle(40);
    check_eq("t1_count", q_n.size(), 1);
    check_eq("t1_latency", wr_cyc_n - frame_cyc0, 155);
    pop_n("t1_data", 32'h0000_00A5);
    check_eq("t1_hold", fifo_n.rx_data, 32'h0000_00A5);
    check_eq("t1_wren_low", {31'd0, fifo_n.rx_wren}, 32'd0);

    // Back-to-back frames with no idle between them
    send_frame(8'h3C, 1'b0, 1'b0, 1'b1);
    send_frame(8'hC3, 1'b0, 1'b0, 1'b1);
    idle(40);
    check_eq("t2_count", q_n.size(), 2);
    pop_n("t2_first", 32'h0000_003C);
    pop_n("t2_second", 32'h0000_00C3);

    // Start-bit glitch
    frame_cyc0 = cyc;
    line = 1'b0;
    repeat (4) @(negedge clk);
    line = 1'b1;
    repeat (2) @(negedge clk);
    check_eq("t3_busy_hi", {31'd0, busy_n}, 32'd1);
    repeat (7) @(negedge clk);
    check_eq("t3_busy_lo", {31'd0, busy_n}, 32'd0);
    idle(200);
    check_eq("t3_no_write", q_n.size(), 0);

    // Framing error
    send_frame(8'h55, 1'b0, 1'b0, 1'b0);
    idle(200);
    check_eq("t4_count", q_n.size(), 1);
    pop_n("t4_data", 32'h0000_0255);
    check_eq("t4_drop", {24'd0, drop_n}, 32'd0);

    // Even parity: bad then good parity bit
    sel_par = 1'b1;
    idle(5);
    send_frame(8'h07, 1'b1, 1'b0, 1'b1);
    idle(40);
    send_frame(8'h07, 1'b1, 1'b1, 1'b1);
    idle(40);
    check_eq("t5_count", q_p.size(), 2);
    pop_p("t5_bad_par", 32'h0000_0107);
    pop_p("t5_good_par", 32'h0000_0007);
    check_eq("t5_np_quiet", q_n.size(), 0);
    sel_par = 1'b0;
    idle(5);

    // FIFO full: drops, overrun flag, then reset mid-frame
    fifo_n.rx_full = 1'b1;
    send_frame(8'h11, 1'b0, 1'b0, 1'b1);
    idle(20);
    send_frame(8'h22, 1'b0, 1'b0, 1'b1);
    idle(40);
    check_eq("t6_no_write", q_n.size(), 0);
    check_eq("t6_drop2", {24'd0, drop_n}, 32'd2);
    fifo_n.rx_full = 1'b0;
    send_frame(8'h33, 1'b0, 1'b0, 1'b1);
    idle(40);
    pop_n("t6_overrun", 32'h0000_0433);
    send_frame(8'h44, 1'b0, 1'b0, 1'b1);
    idle(40);
    pop_n("t6_cleared", 32'h0000_0044);
    check_eq("t6_drop_hold", {24'd0, drop_n}, 32'd2);

    line = 1'b0;
    repeat (60) @(negedge clk);
    rst  = 1'b0;
    line = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("t6_rst_drop", {24'd0, drop_n}, 32'd0);
    check_eq("t6_rst_busy", {31'd0, busy_n}, 32'd0);
    check_eq("t6_rst_data", fifo_n.rx_data, 32'd0);
    rst = 1'b1;
    idle(300);
    check_eq("t6_rst_no_write", q_n.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx_packetizer.md
Name: uart_rx_packetizer

Overview:
- Receive-side endpoint of the UART peripheral: a 16x-oversampled UART receiver running on the system clock.
- Deserialises frames from the external device's TX line and formats each received character, with error flags, into one USB packet word.
- Pushes that word into the RX FIFO (host-bound) over the rx_data/rx_wren/rx_full write interface.
- Drops and counts characters when the FIFO is full.

Parameters:
- BAUD_RATE, 9600, line bit rate in bits/s.
- CLOCK_FREQ, 10000000, clk frequency in Hz. OSR_DIV = CLOCK_FREQ/(BAUD_RATE*16), integer-truncated, must be >= 1.
- PARITY, "none", one of "none" / "even" / "odd".
- DATA_BITS, 8, character length, range 5..8.
- STOP_BITS, 1, number of stop bits checked, 1 or 2.
- USB_PACKET_WIDTH, 32, FIFO word width, must be >= 16.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-low reset (asserted when 0).
- rx  input  1  asynchronous UART line from the external device; idles high.
- rx_data  output  USB_PACKET_WIDTH  packet word to the RX FIFO.
- rx_full  input  1  RX FIFO full.
- rx_wren  output  1  single-cycle FIFO write strobe.
- rx_busy  output  1  high while a frame is in progress (any state except IDLE).
- drop_count  output  8  saturating count of characters dropped because rx_full was high.

Behaviour:
- Reset (rst=0, any time, including mid-frame)
  - State goes to IDLE; the synchroniser flops are set high.
  - rx_wren=0, rx_data=0, rx_busy=0, drop_count=0; tick counter and sample counter cleared.
  - The partial frame is discarded; after release, no write happens until a full new frame arrives.
- Synchroniser
  - rx passes through a 2-flop synchroniser into rx_s. All decisions use rx_s.
- Tick generation
  - A free-running counter of 0..OSR_DIV-1 produces a 1-clk tick on wrap.
  - The counter restarts at 0 on the IDLE->START transition so sampling is frame-aligned.
- FSM
  - IDLE: on rx_s=0, go to START and clear the sample count.
  - START: after 8 ticks (mid start bit), if rx_s=0 go to DATA; else treat as a glitch and return to IDLE with no write.
  - DATA: every 16 ticks, sample rx_s into the shift register, LSB first, DATA_BITS times. Then go to PARITY if PARITY!="none", else STOP.
  - PARITY: after 16 ticks, sample the parity bit.
    - parity_err = 1 if (XOR of data bits) XOR sample != 0 for "even".
    - For "odd", the condition is the inverse (error when that XOR == 0).
  - STOP: STOP_BITS samples, 16 ticks apart. framing_err = 1 if any stop sample = 0. After the last stop sample, go to WRITE.
  - WRITE: lasts 1 clk, then IDLE. IDLE accepts a new falling edge the very next cycle; a frame beginning immediately after the stop mid-point must be received.
- Packet format
  - rx_data[7:0] = character, zero-extended when DATA_BITS<8.
  - rx_data[8] = parity_err, always 0 when PARITY="none".
  - rx_data[9] = framing_err.
  - rx_data[10] = overrun: 1 if at least one character was dropped since the previous successful write. It clears on a successful write.
  - All remaining bits are 0.
- Write handshake
  - In WRITE with rx_full=0: rx_wren=1 for exactly one clk, with rx_data valid in the same cycle.
  - In WRITE with rx_full=1: no write, the overrun flag is set, and drop_count increments, saturating at 255.
  - rx_data holds its last value between writes.
  - Characters with parity or framing errors are still written, with their flags set.
- Latency
  - rx_wren rises exactly 1 clk after the clk that samples the final stop bit.

Test Plan:
Common setup: CLOCK_FREQ=1600000, BAUD_RATE=100000 (OSR_DIV=1, 16 clk/bit), PARITY="none", DATA_BITS=8, STOP_BITS=1.
1. Send 0xA5 with rx_full=0 -> exactly one rx_wren pulse; rx_data=0x000000A5; rx_wren occurs 1 clk after the final stop-bit sample.
2. Send 0x3C and 0xC3 back-to-back with zero idle between them -> two writes, 0x3C then 0xC3, with no errors.
3. Pulse rx low for 4 clk, then high -> no rx_wren; rx_busy returns to 0 within 9 ticks of the falling edge.
4. Send 0x55 with the stop bit driven 0 -> rx_data=0x00000255 (framing_err=1).
5. With PARITY="even", send 0x07 carrying parity bit 0 -> rx_data=0x00000107. Send 0x07 carrying parity bit 1 -> rx_data=0x00000007.
6. With rx_full=1, send 0x11 and 0x22; then set rx_full=0 and send 0x33 -> drop_count=2 and rx_data=0x00000433. A following 0x44 gives rx_data=0x00000044. Asserting rst=0 mid-frame afterward -> drop_count=0 and no write.
